pcm2pdm_modulator: RTL and testbench

PCM2PDM_MODULATOR -- requirements
Module: pcm2pdm_modulator

---
 rtl/pcm2pdm_modulator.sv | 161 ++++++++++++++++
 tb/tb_pcm2pdm_modulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm2pdm_modulator.sv
// PCM to PDM modulator: sample FIFO feeding a first-order sigma-delta stage
// with a programmable PDM bit clock and oversampling ratio.
module pcm2pdm_modulator #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [7:0]  clock_divisor_i,
  input  logic [7:0]  oversample_i,
  input  logic [15:0] pcm_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        clear_i,
  output logic        pdm_clk_o,
  output logic        pdm_o,
  output logic        empty_o,
  output logic        underflow_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   cur_q, cur_d, acc_q, acc_d;
  logic [7:0]    tick_cnt_q, tick_cnt_d, bit_cnt_q, bit_cnt_d;
  logic [7:0]    div_q, div_d, osr_q, osr_d;
  logic          pdm_clk_q, pdm_clk_d, pdm_q, pdm_d, underflow_q, underflow_d;

  logic        full, empty, flush, push, pop, tick, fall_tick, last_bit;
  logic [7:0]  osr_eff;
  logic [15:0] u;
  logic [16:0] sum;

  always_comb begin
    full      = (cnt_q == FullCnt);
    empty     = (cnt_q == '0);
    flush     = (state_q == StRun) && !enable_i;
    ready_o   = !full && !flush;
    push      = valid_i && ready_o;
    osr_eff   = (oversample_i == 8'd0) ? 8'd1 : oversample_i;
    // Ticks are suppressed in the flush cycle so nothing advances while draining.
    tick      = (state_q == StRun) && enable_i && (tick_cnt_q == div_q);
    fall_tick = tick && pdm_clk_q;
    last_bit  = fall_tick && (bit_cnt_q == osr_q - 8'd1);
    pop       = ((state_q == StLoad) || last_bit) && !empty;
    u         = cur_q ^ 16'h8000;
    sum       = {1'b0, acc_q} + {1'b0, u};
  end

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    acc_d       = acc_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    osr_d       = osr_q;
    pdm_clk_d   = pdm_clk_q;
    pdm_d       = pdm_q;
    underflow_d = underflow_q;

    unique case (state_q)
      StIdle:  if (enable_i && !empty) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (!enable_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Rate settings are only picked up at counter wraps to avoid mid-period glitches.
    if (state_q != StRun || tick) div_d = clock_divisor_i;
    if (state_q != StRun || last_bit) osr_d = osr_eff;

    if (state_q == StRun) tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
    if (tick) pdm_clk_d = !pdm_clk_q;

    if (fall_tick) begin
      acc_d     = sum[15:0];
      pdm_d     = sum[16];
      bit_cnt_d = last_bit ? 8'd0 : bit_cnt_q + 8'd1;
    end

    if (push) begin
      mem_d[wptr_q] = pcm_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      cur_d  = mem_q[rptr_q];
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (clear_i) underflow_d = 1'b0;
    else if (last_bit && empty) underflow_d = 1'b1;

    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
      acc_d      = '0;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      pdm_clk_d  = 1'b0;
      pdm_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      cur_q       <= '0;
      acc_q       <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      osr_q       <= 8'd1;
      pdm_clk_q   <= 1'b0;
      pdm_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      osr_q       <= osr_d;
      pdm_clk_q   <= pdm_clk_d;
      pdm_q       <= pdm_d;
      underflow_q <= underflow_d;
    end
  end

  assign pdm_clk_o   = pdm_clk_q;
  assign pdm_o       = pdm_q;
  assign empty_o     = empty;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_pcm2pdm_modulator.sv
// Directed bench for pcm2pdm_modulator: hand-derived PDM bit patterns, FIFO
// full/flush behaviour, underflow handling and asynchronous reset.
module tb_pcm2pdm_modulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  clock_divisor;
  logic [7:0]  oversample;
  logic [15:0] pcm;
  logic        valid;
  logic        ready;
  logic        clear;
  logic        pdm_clk;
  logic        pdm;
  logic        empty;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  pcm2pdm_modulator #(.FIFO_DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .enable_i       (enable),
    .clock_divisor_i(clock_divisor),
    .oversample_i   (oversample),
    .pcm_i          (pcm),
    .valid_i        (valid),
    .ready_o        (ready),
    .clear_i        (clear),
    .pdm_clk_o      (pdm_clk),
    .pdm_o          (pdm),
    .empty_o        (empty),
    .underflow_o    (underflow)
  );

  always #5 clk = ~clk;

  task automatic push_sample(input logic [15:0] s);
    valid = 1'b1;
    pcm   = s;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic start(input logic [7:0] div, input logic [7:0] osr);
    clock_divisor = div;
    oversample    = osr;
    enable        = 1'b1;
  endtask

  task automatic stop();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Returns pdm_o sampled after the next falling pdm_clk_o edge; X on timeout.
  task automatic get_bit(output logic b);
    logic prev;
    logic found;
    prev  = pdm_clk;
    found = 1'b0;
    b     = 1'bx;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (prev && !pdm_clk) begin
        b     = pdm;
        found = 1'b1;
      end
      prev = pdm_clk;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clock_divisor = 8'd1; oversample = 8'd4;
    pcm = '0; valid = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 5;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    if (pdm_clk !== 1'b0) begin errors++; $display("FAIL reset_pdm_clk got %b want 0", pdm_clk); end
    if (pdm !== 1'b0) begin errors++; $display("FAIL reset_pdm got %b want 0", pdm); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
  endtask

  task automatic test_zero_sample();
    logic [3:0] bits;
    logic       b;
    logic       prev;
    int         rises;
    int         period;
    push_sample(16'h0000);
    start(8'd1, 8'd4);
    for (int i = 3; i >= 0; i--) begin get_bit(b); bits[i] = b; end
    checks++;
    if (bits !== 4'b0101) begin errors++; $display("FAIL zero_bits got %b want 0101", bits); end
    rises = 0; period = 0; prev = pdm_clk;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(negedge clk);
      if (rises == 1) period++;
      if (!prev && pdm_clk) rises++;
      prev = pdm_clk;
    end
    checks++;
    if (rises != 2 || period != 4) begin
      errors++; $display("FAIL pdm_clk_period got %0d want 4", period);
    end
    stop();
  endtask

  task automatic test_density();
    logic [7:0]  v8;
    logic [15:0] v16;
    logic        b;
    push_sample(16'h4000);
    start(8'd1, 8'd4);
    for (int i = 7; i >= 0; i--) begin get_bit(b); v8[i] = b; end
    checks++;
    if (v8 !== 8'b0111_0111) begin errors++; $display("FAIL density_4000 got %b want 01110111", v8); end
    stop();
    push_sample(16'h8000);
    start(8'd1, 8'd4);
    for (int i = 7; i >= 0; i--) begin get_bit(b); v8[i] = b; end
    checks++;
    if (v8 !== 8'h00) begin errors++; $display("FAIL density_8000 got %b want 00000000", v8); end
    stop();
    // OSR of zero behaves as one: each bit re-pops and holds the lone sample.
    push_sample(16'h7FFF);
    start(8'd2, 8'd0);
    for (int i = 15; i >= 0; i--) begin get_bit(b); v16[i] = b; end
    checks++;
    if (v16 !== 16'h7FFF) begin errors++; $display("FAIL density_7fff got %h want 7fff", v16); end
    stop();
  endtask

  task automatic test_fifo_full();
    logic [15:0] vals [5];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    clock_divisor = 8'd7; oversample = 8'd4;
    for (int i = 0; i < 4; i++) begin
      push_sample(vals[i]);
      checks++;
      if (ready !== (i < 3)) begin
        errors++; $display("FAIL full_ready_after_%0d got %b want %b", i + 1, ready, i < 3);
      end
    end
    valid = 1'b1; pcm = vals[4];
    repeat (2) @(negedge clk);
    checks += 2;
    if (ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got %b want 0", ready); end
    if (empty !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", empty); end
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b want 1", ready); end
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL full_fifth_accepted got %b want 0", ready); end
    stop();
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL full_flushed got %b want 1", empty); end
  endtask

  task automatic test_flush();
    logic b;
    for (int i = 0; i < 4; i++) push_sample(16'h7FFF);
    start(8'd1, 8'd4);
    get_bit(b);
    get_bit(b);
    repeat (2) @(negedge clk);
    checks += 2;
    if (pdm !== 1'b1) begin errors++; $display("FAIL flush_pre_pdm got %b want 1", pdm); end
    if (pdm_clk !== 1'b1) begin errors++; $display("FAIL flush_pre_clk got %b want 1", pdm_clk); end
    enable = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low got %b want 0", ready); end
    @(negedge clk);
    checks += 4;
    if (pdm_clk !== 1'b0) begin errors++; $display("FAIL flush_pdm_clk got %b want 0", pdm_clk); end
    if (pdm !== 1'b0) begin errors++; $display("FAIL flush_pdm got %b want 0", pdm); end
    if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty); end
    if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready_back got %b want 1", ready); end
    stop();
  endtask

  task automatic test_underflow();
    logic [3:0] bits;
    logic       b;
    push_sample(16'h4000);
    start(8'd1, 8'd2);
    get_bit(b); bits[3] = b;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_early got %b want 0", underflow); end
    get_bit(b); bits[2] = b;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", underflow); end
    get_bit(b); bits[1] = b;
    get_bit(b); bits[0] = b;
    checks++;
    if (bits !== 4'b0111) begin errors++; $display("FAIL uf_held_bits got %b want 0111", bits); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", underflow); end
  endtask

  task automatic test_async_reset();
    logic b;
    get_bit(b);
    get_bit(b);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (pdm_clk !== 1'b0) begin errors++; $display("FAIL arst_pdm_clk got %b want 0", pdm_clk); end
    if (pdm !== 1'b0) begin errors++; $display("FAIL arst_pdm got %b want 0", pdm); end
    if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b want 1", empty); end
    if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", ready); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL arst_underflow got %b want 0", underflow); end
    repeat (3) @(negedge clk);
    checks++;
    if (pdm_clk !== 1'b0) begin errors++; $display("FAIL arst_hold_clk got %b want 0", pdm_clk); end
    rst_n = 1'b1;
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_sample();
    test_density();
    test_fifo_full();
    test_flush();
    test_underflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
